divider_integer_iterative: RTL
==============================

# divider_integer_iterative

Iterative restoring integer divider with ready/valid handshakes on input and output, selectable per-transaction between signed and unsigned operation. It computes a truncated (round-toward-zero) quotient and remainder, flags divide-by-zero and signed overflow, and retires a configurable number of quotient bits per clock. It is the area-efficient, runtime-mode successor to the fixed signed divider: drop-in behind a pipeline fork or join wherever one division is in flight at a time.

## Interface
- WORD_WIDTH, 8: operand and result width in bits; must be ≥ 2.
- STEPS_PER_CYCLE, 1: quotient bits resolved per clock; must divide WORD_WIDTH exactly.
- clock  in  1  sole clock; all state updates on rising edge.
- clear_n  in  1  reset, asynchronous assert, active-low; deassertion is synchronous to clock (synchronised externally).
- input_valid  in  1  operands present.
- input_ready  out  1  block accepts operands this cycle.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
- dividend  in  WORD_WIDTH  numerator.
- divisor  in  WORD_WIDTH  denominator.
- output_valid  out  1  result present.
- output_ready  in  1  consumer takes result this cycle.
- quotient  out  WORD_WIDTH  truncated quotient.
- remainder  out  WORD_WIDTH  remainder; sign follows dividend in signed mode.
- divide_by_zero  out  1  divisor was zero.
- overflow  out  1  signed mode, dividend = most-negative, divisor = −1.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: input_ready=1. On input_valid: register magnitudes of operands (two's-complement negate if is_signed and MSB set), register quotient-sign = sign(dividend) XOR sign(divisor) and remainder-sign = sign(dividend), clear partial remainder, load step counter with WORD_WIDTH/STEPS_PER_CYCLE.
  - Divisor = 0: skip to DONE; quotient = all ones, remainder = dividend unchanged, divide_by_zero=1.
  - Signed most-negative / −1: skip to DONE; quotient = most-negative, remainder = 0, overflow=1.
  - Otherwise → CALC.
- CALC: each cycle performs STEPS_PER_CYCLE chained restoring steps: shift partial remainder left 1 bringing in next dividend MSB, trial-subtract divisor magnitude in WORD_WIDTH+1 bits, keep if non-negative, shift quotient bit in. Counter decrements; at counter reaching 0 → DONE.
- DONE: output_valid=1; outputs are registered magnitudes with sign correction applied (negate quotient if quotient-sign, negate remainder if remainder-sign, signed mode only). Flags valid only here. On output_ready → IDLE.
- input_ready=0 in CALC and DONE; no overlap between transactions.
- Unsigned mode: no negation anywhere; overflow always 0.
- Invariant for normal results: dividend = quotient·divisor + remainder, |remainder| < |divisor|.

## Timing
- Reset (clear_n low, asynchronous): state=IDLE, input_ready=1 after reset releases, output_valid=0, quotient=0, remainder=0, divide_by_zero=0, overflow=0. Reset mid-CALC or mid-DONE abandons the transaction; no result emitted.
- Normal latency: accept edge → output_valid high after WORD_WIDTH/STEPS_PER_CYCLE + 1 rising edges (8 bits, 1 step: 9 cycles; 2 steps: 5 cycles).
- Exception latency (divide-by-zero, overflow): output_valid high the cycle after accept (1 cycle).
- Throughput: one result per N+2 cycles minimum (N = WORD_WIDTH/STEPS_PER_CYCLE), one IDLE cycle between results.
- Output backpressure: output_valid, quotient, remainder, flags held stable while output_ready=0; output_valid never drops without handshake.
- output_ready asserted while output_valid=0 has no effect. input_valid while input_ready=0 is ignored; operands need not be held.
- Handshake on DONE exit and input_valid on the same cycle: operands are not accepted until the following IDLE cycle.

## Test plan
- WORD_WIDTH=8, unsigned 200/7 → quotient 28, remainder 4, flags 0, output_valid 9 cycles after accept; 8 bits, STEPS_PER_CYCLE=2 → same values, 5 cycles.
- Signed −7/2 (0xF9/0x02) → quotient 0xFD (−3), remainder 0xFF (−1); signed 7/−2 → 0xFD, 0x01; same 0xF9/0x02 unsigned → quotient 124, remainder 1.
- Signed 0x80/0xFF → quotient 0x80, remainder 0x00, overflow=1, 1-cycle latency; same operands unsigned → quotient 0, remainder 0x80, overflow=0.
- 0x55/0x00 either mode → quotient 0xFF, remainder 0x55, divide_by_zero=1, 1-cycle latency.
- Hold output_ready=0 for 5 cycles in DONE → outputs stable, input_ready=0, new input_valid ignored; release → one handshake, IDLE next cycle, next operation accepted.
- Assert clear_n=0 in CALC cycle 4 → output_valid=0 and all outputs 0 immediately; after release, 100/10 unsigned → quotient 10, remainder 0, with full latency.

Source files
------------

// File: rtl/divider_integer_iterative.sv
// divider_integer_iterative -- iterative restoring integer divider.
//
// One division in flight at a time. Operands are accepted on an input
// ready/valid handshake, reduced to magnitudes, divided by STEPS_PER_CYCLE
// restoring steps per clock, sign-corrected and presented on an output
// ready/valid handshake. Quotient truncates toward zero; the remainder takes
// the sign of the dividend in signed mode.
//
// Parameters
//   WORD_WIDTH      operand/result width (>= 2)
//   STEPS_PER_CYCLE quotient bits resolved per clock (must divide WORD_WIDTH)
//
// Ports
//   clock          rising-edge clock
//   clear_n        async active-low reset
//   input_valid/_ready   operand handshake (ready only in IDLE)
//   is_signed      1 = two's-complement operands, sampled with operands
//   dividend, divisor    operands
//   output_valid/_ready  result handshake (valid only in DONE)
//   quotient, remainder  results (zero outside DONE)
//   divide_by_zero, overflow  exception flags, meaningful only in DONE

// One restoring step: shift the next dividend bit into the partial remainder,
// trial-subtract the divisor, keep the difference if it did not borrow, and
// shift the resulting quotient bit into the low end of the dividend register.
module divider_integer_iterative_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] num_i,
  input  logic [W-1:0] den_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] num_o
);
  logic [W:0] shifted;
  logic [W:0] diff;
  logic       qbit;

  // rem_i < den_i, so shifted < 2*den_i and the W+1-bit difference has its
  // top bit set exactly when the trial subtraction goes negative.
  assign shifted = {rem_i, num_i[W-1]};
  assign diff    = shifted - {1'b0, den_i};
  assign qbit    = ~diff[W];
  assign rem_o   = qbit ? diff[W-1:0] : shifted[W-1:0];
  assign num_o   = {num_i[W-2:0], qbit};
endmodule

module divider_integer_iterative #(
  parameter int WORD_WIDTH      = 8,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic                  is_signed,
  input  logic [WORD_WIDTH-1:0] dividend,
  input  logic [WORD_WIDTH-1:0] divisor,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [WORD_WIDTH-1:0] quotient,
  output logic [WORD_WIDTH-1:0] remainder,
  output logic                  divide_by_zero,
  output logic                  overflow
);
  localparam int W     = WORD_WIDTH;
  localparam int SPC   = STEPS_PER_CYCLE;
  localparam int NITER = W / SPC;
  localparam int CW    = $clog2(NITER + 1);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  // num_q holds the dividend magnitude; quotient bits shift in from the
  // bottom as dividend bits leave the top, so it ends up as the quotient.
  logic [W-1:0]  num_q, num_d;
  logic [W-1:0]  den_q, den_d;
  logic [W-1:0]  prem_q, prem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  // Operand magnitudes and signs, evaluated on the raw inputs.
  logic          a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag;
  logic          is_ovf;

  assign a_neg  = is_signed & dividend[W-1];
  assign b_neg  = is_signed & divisor[W-1];
  assign a_mag  = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_mag  = b_neg ? (~divisor + 1'b1) : divisor;
  assign is_ovf = is_signed && (dividend == MOST_NEG) && (divisor == '1);

  // Chain of restoring steps evaluated combinationally each CALC cycle.
  logic [SPC:0][W-1:0] chain_rem;
  logic [SPC:0][W-1:0] chain_num;

  assign chain_rem[0] = prem_q;
  assign chain_num[0] = num_q;

  for (genvar s = 0; s < SPC; s++) begin : g_step
    divider_integer_iterative_step #(.W(W)) u_step (
      .rem_i (chain_rem[s]),
      .num_i (chain_num[s]),
      .den_i (den_q),
      .rem_o (chain_rem[s+1]),
      .num_o (chain_num[s+1])
    );
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      den_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      den_q   <= den_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    den_d   = den_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (input_valid) begin
          num_d  = a_mag;
          den_d  = b_mag;
          prem_d = '0;
          cnt_d  = CW'(NITER);
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          dbz_d  = 1'b0;
          ovf_d  = 1'b0;
          if (divisor == '0) begin
            // Final values stored directly; sign correction disabled.
            num_d   = '1;
            prem_d  = dividend;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else if (is_ovf) begin
            num_d   = MOST_NEG;
            prem_d  = '0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            ovf_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        num_d  = chain_num[SPC];
        prem_d = chain_rem[SPC];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (output_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic in_done;
  assign in_done = (state_q == ST_DONE);

  assign input_ready    = (state_q == ST_IDLE);
  assign output_valid   = in_done;
  assign quotient       = in_done ? (qneg_q ? (~num_q + 1'b1) : num_q) : '0;
  assign remainder      = in_done ? (rneg_q ? (~prem_q + 1'b1) : prem_q) : '0;
  assign divide_by_zero = in_done & dbz_q;
  assign overflow       = in_done & ovf_q;
endmodule
